// File: rtl/mem_stall_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage stall controller and the memory.
interface mem_stall_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stall_ctrl.sv
// MEM-stage sequencer: freezes the upstream pipeline around a variable-latency data access
// and steers the MEM/WB load so each memory instruction commits exactly once.
module mem_stall_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemReadMEM,
  input  logic              MemWriteMEM,
  mem_stall_ctrl_if.master  dmem,
  output logic [31:0]       dmemout,
  output logic              stall,
  output logic              memwb_en,
  output logic              memwb_bubble,
  output logic              timeout_err,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        stateQ, stateD;
  logic [CNT_W-1:0]  cntQ, cntD;
  logic [31:0]       rdataQ, rdataD;
  logic              timeoutErrQ, timeoutErrD;
  logic [PERF_W-1:0] stallCyclesQ;
  logic              memop;
  logic              req, we;

  assign memop = MemReadMEM | MemWriteMEM;

  always_comb begin
    stateD       = stateQ;
    cntD         = cntQ;
    rdataD       = rdataQ;
    timeoutErrD  = timeoutErrQ;
    stall        = 1'b0;
    req          = 1'b0;
    we           = 1'b0;
    memwb_en     = 1'b1;
    memwb_bubble = 1'b0;
    case (stateQ)
      StIdle: begin
        // Any ack seen here is stale and is deliberately ignored.
        if (memop) begin
          stall        = 1'b1;
          req          = 1'b1;
          we           = MemWriteMEM;
          memwb_bubble = 1'b1;
          cntD         = '0;
          stateD       = StWait;
        end
      end
      StWait: begin
        stall        = 1'b1;
        req          = 1'b1;
        we           = MemWriteMEM;
        memwb_bubble = 1'b1;
        if (dmem.dmem_ack) begin
          rdataD = dmem.dmem_rdata;
          stateD = StDone;
        end else if (cntQ == CNT_W'(TIMEOUT - 1)) begin
          timeoutErrD = 1'b1;
          rdataD      = '0;
          stateD      = StDone;
        end else begin
          cntD = cntQ + CNT_W'(1);
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
    // Reset flushes MEM/WB with a bubble and withdraws any outstanding request.
    if (!rst_n) begin
      stall        = 1'b0;
      req          = 1'b0;
      we           = 1'b0;
      memwb_en     = 1'b1;
      memwb_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ       <= StIdle;
      cntQ         <= '0;
      rdataQ       <= '0;
      timeoutErrQ  <= 1'b0;
      stallCyclesQ <= '0;
    end else begin
      stateQ      <= stateD;
      cntQ        <= cntD;
      rdataQ      <= rdataD;
      timeoutErrQ <= timeoutErrD;
      if (stall && (stallCyclesQ != {PERF_W{1'b1}})) begin
        stallCyclesQ <= stallCyclesQ + PERF_W'(1);
      end
    end
  end

  assign dmem.dmem_req = req;
  assign dmem.dmem_we  = we;
  assign dmemout       = rdataQ;
  assign timeout_err   = timeoutErrQ;
  assign stall_cycles  = stallCyclesQ;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl: one table row per clock cycle plus hand-written
// timeout and reset sequences.
module tb_mem_stall_ctrl;

  logic        clk;
  logic        rst_n;
  logic        MemReadMEM;
  logic        MemWriteMEM;
  logic [31:0] dmemout;
  logic        stall;
  logic        memwb_en;
  logic        memwb_bubble;
  logic        timeout_err;
  logic [15:0] stall_cycles;

  mem_stall_ctrl_if bus ();

  mem_stall_ctrl #(
    .TIMEOUT (15),
    .CNT_W   (4),
    .PERF_W  (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MemReadMEM   (MemReadMEM),
    .MemWriteMEM  (MemWriteMEM),
    .dmem         (bus),
    .dmemout      (dmemout),
    .stall        (stall),
    .memwb_en     (memwb_en),
    .memwb_bubble (memwb_bubble),
    .timeout_err  (timeout_err),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstN;
    logic        rd;
    logic        wr;
    logic        ack;
    logic [31:0] rdata;
    logic        expReq;
    logic        expWe;
    logic        expStall;
    logic        expEn;
    logic        expBub;
    logic [31:0] expDout;
    logic [15:0] expSc;
    logic        expTe;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  function automatic void addRow(logic rstN, logic rd, logic wr, logic ack, logic [31:0] rdata,
                                 logic req, logic we, logic st, logic en, logic bub,
                                 logic [31:0] dout, logic [15:0] sc, logic te);
    vec_t v;
    v.rstN = rstN; v.rd = rd; v.wr = wr; v.ack = ack; v.rdata = rdata;
    v.expReq = req; v.expWe = we; v.expStall = st; v.expEn = en; v.expBub = bub;
    v.expDout = dout; v.expSc = sc; v.expTe = te;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge; outputs settle before the #1 sample.
  task automatic cyc(logic rstN, logic rd, logic wr, logic ack, logic [31:0] rdata);
    @(negedge clk);
    rst_n          = rstN;
    MemReadMEM     = rd;
    MemWriteMEM    = wr;
    bus.dmem_ack   = ack;
    bus.dmem_rdata = rdata;
    #1;
  endtask

  task automatic checkIdleOuts(string tag);
    check({tag, ".req"}, {31'b0, bus.dmem_req}, 32'd0);
    check({tag, ".stall"}, {31'b0, stall}, 32'd0);
    check({tag, ".bubble"}, {31'b0, memwb_bubble}, 32'd0);
  endtask

  task automatic checkWaitOuts(string tag);
    check({tag, ".req"}, {31'b0, bus.dmem_req}, 32'd1);
    check({tag, ".stall"}, {31'b0, stall}, 32'd1);
    check({tag, ".bubble"}, {31'b0, memwb_bubble}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; MemReadMEM = 1'b0; MemWriteMEM = 1'b0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;

    // Columns: rstN rd wr ack rdata | req we stall en bubble dmemout stall_cycles timeout_err
    // ALU-only stream
    for (int i = 0; i < 10; i++) addRow(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 16'd0, 0);
    // Load acked one cycle after the request
    addRow(1, 1, 0, 0, 32'h0,        1, 0, 1, 1, 1, 32'h0,        16'd0, 0);
    addRow(1, 1, 0, 1, 32'h12345678, 1, 0, 1, 1, 1, 32'h0,        16'd1, 0);
    addRow(1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h12345678, 16'd2, 0);
    addRow(1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h12345678, 16'd2, 0);
    // Store acked four cycles after the request
    addRow(1, 0, 1, 0, 32'h0,        1, 1, 1, 1, 1, 32'h12345678, 16'd2, 0);
    addRow(1, 0, 1, 0, 32'h0,        1, 1, 1, 1, 1, 32'h12345678, 16'd3, 0);
    addRow(1, 0, 1, 0, 32'h0,        1, 1, 1, 1, 1, 32'h12345678, 16'd4, 0);
    addRow(1, 0, 1, 0, 32'h0,        1, 1, 1, 1, 1, 32'h12345678, 16'd5, 0);
    addRow(1, 0, 1, 1, 32'hDEADBEEF, 1, 1, 1, 1, 1, 32'h12345678, 16'd6, 0);
    addRow(1, 0, 1, 0, 32'h0,        0, 0, 0, 1, 0, 32'hDEADBEEF, 16'd7, 0);
    addRow(1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 32'hDEADBEEF, 16'd7, 0);
    // Back-to-back loads returning 0xA then 0xB
    addRow(1, 1, 0, 0, 32'h0,        1, 0, 1, 1, 1, 32'hDEADBEEF, 16'd7, 0);
    addRow(1, 1, 0, 1, 32'hA,        1, 0, 1, 1, 1, 32'hDEADBEEF, 16'd8, 0);
    addRow(1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 0, 32'hA,        16'd9, 0);
    addRow(1, 1, 0, 0, 32'h0,        1, 0, 1, 1, 1, 32'hA,        16'd9, 0);
    addRow(1, 1, 0, 1, 32'hB,        1, 0, 1, 1, 1, 32'hA,        16'd10, 0);
    addRow(1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 0, 32'hB,        16'd11, 0);
    addRow(1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 32'hB,        16'd11, 0);
    // Reset asserted in the third WAIT cycle, stray ack afterwards
    addRow(1, 1, 0, 0, 32'h0,        1, 0, 1, 1, 1, 32'hB,        16'd11, 0);
    addRow(1, 1, 0, 0, 32'h0,        1, 0, 1, 1, 1, 32'hB,        16'd12, 0);
    addRow(1, 1, 0, 0, 32'h0,        1, 0, 1, 1, 1, 32'hB,        16'd13, 0);
    addRow(0, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'hB,        16'd14, 0);
    addRow(1, 0, 0, 1, 32'h55,       0, 0, 0, 1, 0, 32'h0,        16'd0, 0);
    // A memop right after the stray ack must see IDLE (request raised, nothing captured)
    addRow(1, 1, 0, 0, 32'h0,        1, 0, 1, 1, 1, 32'h0,        16'd0, 0);
    addRow(1, 1, 0, 1, 32'h77,       1, 0, 1, 1, 1, 32'h0,        16'd1, 0);
    addRow(1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h77,       16'd2, 0);
    addRow(1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h77,       16'd2, 0);

    // Initial reset: outputs forced while rst_n is low
    cyc(0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'hFFFF_FFFF);
    check("rst.req", {31'b0, bus.dmem_req}, 32'd0);
    check("rst.we", {31'b0, bus.dmem_we}, 32'd0);
    check("rst.stall", {31'b0, stall}, 32'd0);
    check("rst.en", {31'b0, memwb_en}, 32'd1);
    check("rst.bubble", {31'b0, memwb_bubble}, 32'd1);
    check("rst.dmemout", dmemout, 32'h0);
    check("rst.sc", {16'b0, stall_cycles}, 32'd0);
    check("rst.te", {31'b0, timeout_err}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rstN, vecs[i].rd, vecs[i].wr, vecs[i].ack, vecs[i].rdata);
      check($sformatf("v%0d.req", i), {31'b0, bus.dmem_req}, {31'b0, vecs[i].expReq});
      check($sformatf("v%0d.we", i), {31'b0, bus.dmem_we}, {31'b0, vecs[i].expWe});
      check($sformatf("v%0d.stall", i), {31'b0, stall}, {31'b0, vecs[i].expStall});
      check($sformatf("v%0d.en", i), {31'b0, memwb_en}, {31'b0, vecs[i].expEn});
      check($sformatf("v%0d.bubble", i), {31'b0, memwb_bubble}, {31'b0, vecs[i].expBub});
      check($sformatf("v%0d.dmemout", i), dmemout, vecs[i].expDout);
      check($sformatf("v%0d.sc", i), {16'b0, stall_cycles}, {16'b0, vecs[i].expSc});
      check($sformatf("v%0d.te", i), {31'b0, timeout_err}, {31'b0, vecs[i].expTe});
    end

    // Load never acked: IDLE cycle, 15 WAIT cycles, then DONE with zero data and a sticky error
    cyc(1, 1, 0, 0, 32'h0);
    checkWaitOuts("to.idle");
    for (int w = 0; w < 15; w++) begin
      cyc(1, 1, 0, 0, 32'h0);
      checkWaitOuts($sformatf("to.w%0d", w));
    end
    cyc(1, 1, 0, 0, 32'h0);
    checkIdleOuts("to.done");
    check("to.done.dmemout", dmemout, 32'h0);
    check("to.done.te", {31'b0, timeout_err}, 32'd1);
    check("to.done.sc", {16'b0, stall_cycles}, 32'd18);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 32'h0);
      checkIdleOuts($sformatf("to.alu%0d", i));
      check($sformatf("to.alu%0d.te", i), {31'b0, timeout_err}, 32'd1);
    end

    // Reset clears the error; ack on the 15th WAIT cycle beats the timeout
    cyc(0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 32'h0);
    check("late.rst.te", {31'b0, timeout_err}, 32'd0);
    cyc(1, 1, 0, 0, 32'h0);
    for (int w = 0; w < 14; w++) cyc(1, 1, 0, 0, 32'h0);
    cyc(1, 1, 0, 1, 32'h99);
    checkWaitOuts("late.w14");
    cyc(1, 1, 0, 0, 32'h0);
    checkIdleOuts("late.done");
    check("late.done.dmemout", dmemout, 32'h99);
    check("late.done.te", {31'b0, timeout_err}, 32'd0);
    check("late.done.sc", {16'b0, stall_cycles}, 32'd16);
    cyc(1, 0, 0, 0, 32'h0);
    check("late.after.te", {31'b0, timeout_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
- Sequences the MEM stage of the 5-stage pipeline around a variable-latency data memory.
- Detects load/store in MEM and issues a req/ack handshake to the memory.
- Freezes all upstream pipeline registers while the access is pending.
- Drives load-enable and bubble-insert for the MEM/WB register so WB never commits a stalled or duplicated instruction. Captured load data is presented to MEM/WB on the completion cycle.

Parameters:
- TIMEOUT, 15, max WAIT cycles without ack before the access is abandoned (1..2^CNT_W-1)
- CNT_W, 4, width of wait counter
- PERF_W, 16, width of saturating stall-cycle counter

Ports:
- clk  input  1  pipeline clock; all state updates on posedge
- rst_n  input  1  synchronous active-low reset
- MemReadMEM  input  1  instruction in MEM is a load
- MemWriteMEM  input  1  instruction in MEM is a store
- dmem_ack  input  1  memory completion strobe, one cycle
- dmem_rdata  input  32  memory read data, valid with dmem_ack
- dmem_req  output  1  access request to data memory
- dmem_we  output  1  write qualifier, valid with dmem_req
- dmemout  output  32  load data to MEM/WB dmem input
- stall  output  1  hold PC, IF/ID, ID/EX, EX/MEM
- memwb_en  output  1  MEM/WB load enable
- memwb_bubble  output  1  force RegWrite/MemtoReg to 0 in the MEM/WB load
- timeout_err  output  1  sticky: an access timed out
- stall_cycles  output  PERF_W  saturating count of stalled cycles

Behaviour:
- State machine: IDLE, WAIT, DONE. memop = MemReadMEM | MemWriteMEM.
- Outputs are combinational from state and inputs; all registers update on posedge clk.
- IDLE, memop=0:
  - stall=0, dmem_req=0, memwb_en=1, memwb_bubble=0; stay IDLE.
- IDLE, memop=1:
  - stall=1, dmem_req=1, dmem_we=MemWriteMEM, memwb_en=1, memwb_bubble=1.
  - Clear cnt; go WAIT. dmem_ack is ignored in IDLE; memory must not ack in the request's first cycle.
- WAIT:
  - stall=1, dmem_req=1, dmem_we=MemWriteMEM, memwb_en=1, memwb_bubble=1.
  - dmem_ack=1: rdata_q <= dmem_rdata (store: don't-care but still captured); go DONE.
  - else if cnt==TIMEOUT-1: timeout_err <= 1, rdata_q <= 0; go DONE.
  - else cnt <= cnt+1.
  - ack and timeout in the same cycle: ack wins, no error.
- DONE:
  - stall=0, dmem_req=0, memwb_en=1, memwb_bubble=0; the instruction advances into MEM/WB with dmemout=rdata_q.
  - Always go IDLE next. A back-to-back memop then starts a new request; no request is issued in DONE.
- dmemout = rdata_q in all states; it is only consumed when MemtoReg is set and no bubble is inserted.
- Latency: memory op with ack k cycles after first req (k>=1) occupies k+2 cycles in MEM (IDLE, k WAIT, DONE). Non-memop takes 1 cycle.
- stall_cycles increments each cycle stall=1 and saturates at all-ones.
- timeout_err clears only on reset.
- dmem_req, once raised, stays high until ack or timeout. dmem_we is constant for the whole request, because stall holds EX/MEM.
- Reset (rst_n=0 at posedge):
  - Next state IDLE; cnt=0, rdata_q=0, timeout_err=0, stall_cycles=0.
  - While rst_n=0, outputs are forced: dmem_req=0, dmem_we=0, stall=0, memwb_en=1, memwb_bubble=1, which flushes MEM/WB.
  - Reset in WAIT abandons the access without error. A late ack arriving in IDLE is ignored.
- Unknown state encoding recovers to IDLE.

Test Plan:
1. ALU-only stream (MemReadMEM=MemWriteMEM=0) for 10 cycles -> stall=0, memwb_en=1, memwb_bubble=0 every cycle; stall_cycles=0.
2. Load with ack 1 cycle after req, dmem_rdata=0x12345678 -> states IDLE/WAIT/DONE; stall=1 for 2 cycles; bubble=1 for 2 cycles; in DONE dmemout=0x12345678, bubble=0; stall_cycles=2.
3. Store with ack after 4 cycles -> dmem_req=1 and dmem_we=1 for 5 consecutive cycles; stall for 5 cycles; DONE then IDLE; timeout_err=0.
4. Load, no ack, TIMEOUT=15 -> 15 WAIT cycles then DONE with dmemout=0, timeout_err=1 sticky through a following ALU stream. Variant: ack on the 15th WAIT cycle -> no error.
5. Back-to-back loads, each acked after 1 cycle with 0xA and 0xB -> sequence IDLE,WAIT,DONE,IDLE,WAIT,DONE; dmem_req low in first DONE; dmemout 0xA then 0xB.
6. rst_n=0 during the 3rd WAIT cycle, then ack pulse after release -> dmem_req drops immediately; memwb_bubble=1 during reset; state IDLE; stray ack produces no DONE; counters 0.
